// File: rtl/cei_mochila_pkg.sv
// Shared types and constants for the OBI error responder slice.
// ERR_RESP_WDATA_LOG_EN adds write data to each fault-log entry.
package cei_mochila_pkg;

  typedef enum logic {
    IRQ_TYPE_LEVEL,
    IRQ_TYPE_EDGE
  } irq_type_e;

  localparam int unsigned ERR_IDX           = 0;
  localparam irq_type_e   ERR_IRQ_TYPE      = IRQ_TYPE_EDGE;
  localparam logic [31:0] ERR_RDATA_PATTERN = 32'hBADACCE5;
  localparam int unsigned ERR_LOG_DEPTH     = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
`ifdef ERR_RESP_WDATA_LOG_EN
    logic [31:0] wdata;
`endif
  } err_log_entry_t;

  function automatic bit irq_is_edge(irq_type_e t);
    return t == IRQ_TYPE_EDGE;
  endfunction

endpackage

// File: rtl/obi_error_responder_err_log_fifo.sv
// Synchronous FIFO of fault-log entries; pointers carry an extra wrap bit.
module err_log_fifo
  import cei_mochila_pkg::*;
#(
  parameter int unsigned DEPTH = ERR_LOG_DEPTH
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_flush,
  input  logic           i_push,
  input  err_log_entry_t i_data,
  input  logic           i_pop,
  output err_log_entry_t o_head,
  output logic           o_full,
  output logic           o_empty,
  output logic           o_push_ok
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]    r_wptr;
  logic [AW:0]    r_rptr;
  err_log_entry_t r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !w_empty;
  // A pop in the same cycle frees the slot a full log needs for the push.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  always_comb begin
    o_head = '0;
    if (!w_empty) o_head = r_mem[r_rptr[AW-1:0]];
  end

  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_push_ok = w_do_push;

endmodule

// File: rtl/obi_error_responder.sv
// Default OBI slave: completes every access, returns a poison pattern, logs faults.
// ERR_RESP_WDATA_LOG_EN adds write data to the log and the log_wdata_o port.
module obi_error_responder
  import cei_mochila_pkg::*;
#(
  parameter logic [31:0] RDATA_PATTERN = ERR_RDATA_PATTERN,
  parameter int unsigned LOG_DEPTH     = ERR_LOG_DEPTH,
  parameter int unsigned CNT_W         = 16,
  parameter bit          IRQ_EDGE      = irq_is_edge(ERR_IRQ_TYPE)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic [31:0]      addr_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [31:0]      wdata_i,
  output logic             rvalid_o,
  output logic [31:0]      rdata_o,
  input  logic             log_pop_i,
  output logic [31:0]      log_addr_o,
  output logic             log_we_o,
`ifdef ERR_RESP_WDATA_LOG_EN
  output logic [31:0]      log_wdata_o,
`endif
  output logic             log_empty_o,
  output logic             log_ovf_o,
  output logic [CNT_W-1:0] fault_cnt_o,
  input  logic             clear_i,
  output logic             irq_o
);

  logic             w_hs;
  logic             w_push;
  logic             w_push_ok;
  logic             w_log_empty;
  logic             w_log_full;
  err_log_entry_t   w_entry;
  err_log_entry_t   w_head;

  logic             r_rvalid;
  logic [31:0]      r_rdata;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_irq;

  assign gnt_o  = req_i;
  assign w_hs   = req_i;
  // Clear wins over a coincident handshake: still answered, never recorded.
  assign w_push = w_hs && !clear_i;

  always_comb begin
    w_entry      = '0;
    w_entry.addr = addr_i;
    w_entry.we   = we_i;
`ifdef ERR_RESP_WDATA_LOG_EN
    w_entry.wdata = we_i ? wdata_i : '0;
`endif
  end

`ifdef ERR_RESP_WDATA_LOG_EN
  logic w_unused;
  assign w_unused = ^be_i;
`else
  logic w_unused;
  assign w_unused = ^{be_i, wdata_i};
`endif

  err_log_fifo #(
    .DEPTH(LOG_DEPTH)
  ) u_log (
    .i_clk    (clk_i),
    .i_rst_n  (rst_ni),
    .i_flush  (clear_i),
    .i_push   (w_push),
    .i_data   (w_entry),
    .i_pop    (log_pop_i && !clear_i),
    .o_head   (w_head),
    .o_full   (w_log_full),
    .o_empty  (w_log_empty),
    .o_push_ok(w_push_ok)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_hs;
      if (w_hs) r_rdata <= we_i ? '0 : RDATA_PATTERN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_irq <= 1'b0;
    end else if (clear_i) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_hs && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
      if (w_push && !w_push_ok)  r_ovf <= 1'b1;
      if (IRQ_EDGE) r_irq <= w_push_ok;
      else          r_irq <= !w_log_empty;
    end
  end

  assign rvalid_o    = r_rvalid;
  assign rdata_o     = r_rdata;
  assign log_addr_o  = w_head.addr;
  assign log_we_o    = w_head.we;
`ifdef ERR_RESP_WDATA_LOG_EN
  assign log_wdata_o = w_head.wdata;
`endif
  assign log_empty_o = w_log_empty;
  assign log_ovf_o   = r_ovf;
  assign fault_cnt_o = r_cnt;
  assign irq_o       = r_irq;

endmodule

// File: tb/tb_obi_error_responder.sv
// Randomized + directed bench for obi_error_responder against a queue-based model.
module tb_obi_error_responder;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;
  localparam logic [31:0] PAT     = 32'hBADACCE5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0, we = 1'b0, pop = 1'b0, clr = 1'b0;
  logic [31:0]   addr = '0, wdata = '0;
  logic [3:0]    be = 4'hF;
  logic          gnt, rvalid, log_we, log_empty, log_ovf, irq;
  logic [31:0]   rdata, log_addr;
  logic [CW-1:0] cnt;
  logic          irq_lvl;
  logic          lvl_unused_gnt, lvl_unused_rv, lvl_unused_we, lvl_unused_emp, lvl_unused_ovf;
  logic [31:0]   lvl_unused_rd, lvl_unused_addr;
  logic [CW-1:0] lvl_unused_cnt;
`ifdef ERR_RESP_WDATA_LOG_EN
  logic [31:0]   log_wdata, lvl_unused_wd;
`endif

  always #5 clk = ~clk;

  obi_error_responder #(.CNT_W(CW), .LOG_DEPTH(DEPTH), .IRQ_EDGE(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .log_pop_i(pop),
    .log_addr_o(log_addr), .log_we_o(log_we),
`ifdef ERR_RESP_WDATA_LOG_EN
    .log_wdata_o(log_wdata),
`endif
    .log_empty_o(log_empty), .log_ovf_o(log_ovf), .fault_cnt_o(cnt), .clear_i(clr), .irq_o(irq)
  );

  obi_error_responder #(.CNT_W(CW), .LOG_DEPTH(DEPTH), .IRQ_EDGE(1'b0)) u_lvl (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(lvl_unused_gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(lvl_unused_rv), .rdata_o(lvl_unused_rd), .log_pop_i(pop),
    .log_addr_o(lvl_unused_addr), .log_we_o(lvl_unused_we),
`ifdef ERR_RESP_WDATA_LOG_EN
    .log_wdata_o(lvl_unused_wd),
`endif
    .log_empty_o(lvl_unused_emp), .log_ovf_o(lvl_unused_ovf), .fault_cnt_o(lvl_unused_cnt),
    .clear_i(clr), .irq_o(irq_lvl)
  );

  // ---- behavioural model ----
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } ent_t;

  ent_t        m_log[$];
  int          m_cnt;
  bit          m_ovf, m_rvalid, m_irq_e, m_irq_l;
  logic [31:0] m_rdata;
  bit          chk_en = 1'b0;
  int          n_vec = 0, n_mis = 0;

  task automatic model_reset();
    m_log.delete();
    m_cnt = 0; m_ovf = 0; m_rvalid = 0; m_irq_e = 0; m_irq_l = 0; m_rdata = '0;
  endtask

  task automatic model_update();
    ent_t e;
    bit   was_nonempty;
    was_nonempty = (m_log.size() != 0);
    m_rvalid = req;
    if (req) m_rdata = we ? 32'h0 : PAT;
    if (clr) begin
      m_log.delete();
      m_cnt = 0; m_ovf = 0; m_irq_e = 0; m_irq_l = 0;
    end else begin
      m_irq_l = was_nonempty;
      m_irq_e = 0;
      if (pop && m_log.size() > 0) void'(m_log.pop_front());
      if (req) begin
        if (m_log.size() < DEPTH) begin
          e.addr = addr; e.we = we; e.wdata = we ? wdata : 32'h0;
          m_log.push_back(e);
          m_irq_e = 1;
        end else begin
          m_ovf = 1;
        end
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      chk("gnt", {31'b0, gnt}, {31'b0, req});
      chk("rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
      chk("rdata", rdata, m_rdata);
      chk("log_empty", {31'b0, log_empty}, {31'b0, m_log.size() == 0});
      chk("log_addr", log_addr, (m_log.size() != 0) ? m_log[0].addr : 32'h0);
      chk("log_we", {31'b0, log_we}, {31'b0, (m_log.size() != 0) ? m_log[0].we : 1'b0});
`ifdef ERR_RESP_WDATA_LOG_EN
      chk("log_wdata", log_wdata, (m_log.size() != 0) ? m_log[0].wdata : 32'h0);
`endif
      chk("log_ovf", {31'b0, log_ovf}, {31'b0, m_ovf});
      chk("fault_cnt", {28'b0, cnt}, m_cnt);
      chk("irq_edge", {31'b0, irq}, {31'b0, m_irq_e});
      chk("irq_level", {31'b0, irq_lvl}, {31'b0, m_irq_l});
    end
  end

  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic p, input logic c);
    @(negedge clk);
    req = r; we = w; addr = a; wdata = d; pop = p; clr = c;
    @(posedge clk);
    model_update();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 0; we = 0; pop = 0; clr = 0; addr = '0; wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    do_reset();
    #3;
    chk("reset_rvalid", {31'b0, rvalid}, 32'h0);
    chk("reset_empty", {31'b0, log_empty}, 32'h1);
    chk("reset_cnt", {28'b0, cnt}, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);

    // Single read at the poison window.
    step(1, 0, 32'hBADACCE5, 32'h0, 0, 0);
    #3;
    chk("rd_rvalid", {31'b0, rvalid}, 32'h1);
    chk("rd_rdata", rdata, 32'hBADACCE5);
    chk("rd_log_addr", log_addr, 32'hBADACCE5);
    chk("rd_cnt", {28'b0, cnt}, 32'h1);
    chk("rd_irq", {31'b0, irq}, 32'h1);
    idle();
    #3;
    chk("rd_irq_drop", {31'b0, irq}, 32'h0);
    chk("rd_rdata_hold", rdata, 32'hBADACCE5);

    // Six back-to-back writes overflow a 4-deep log.
    step(0, 0, 32'h0, 32'h0, 0, 1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 32'h5000_0000 + 32'(4 * i), 32'h1000 + 32'(i), 0, 0);
      #3;
      if (irq) pulses++;
      chk("wr_rvalid", {31'b0, rvalid}, 32'h1);
    end
    idle();
    #3;
    chk("wr_pulses", pulses, 32'd4);
    chk("wr_cnt", {28'b0, cnt}, 32'd6);
    chk("wr_ovf", {31'b0, log_ovf}, 32'h1);
    chk("wr_head", log_addr, 32'h5000_0000);
    chk("wr_rdata", rdata, 32'h0);

    // Full log, push and pop together.
    step(0, 0, 32'h0, 32'h0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 32'h5000_0000 + 32'(4 * i), 32'h0, 0, 0);
    step(1, 0, 32'h6000_0000, 32'h0, 1, 0);
    #3;
    chk("pp_ovf", {31'b0, log_ovf}, 32'h0);
    chk("pp_head", log_addr, 32'h5000_0004);
    chk("pp_cnt", {28'b0, cnt}, 32'd5);
    chk("pp_irq", {31'b0, irq}, 32'h1);

    // Saturation then clear.
    for (int i = 0; i < 20; i++) step(1, 0, 32'h7000_0000, 32'h0, 0, 0);
    #3;
    chk("sat_cnt", {28'b0, cnt}, 32'd15);
    step(0, 0, 32'h0, 32'h0, 0, 1);
    #3;
    chk("clr_cnt", {28'b0, cnt}, 32'h0);
    chk("clr_empty", {31'b0, log_empty}, 32'h1);
    chk("clr_ovf", {31'b0, log_ovf}, 32'h0);

    // Clear coincident with a read handshake.
    step(1, 1, 32'h1, 32'h0, 0, 0);
    step(1, 0, 32'h8000_0000, 32'h0, 0, 1);
    #3;
    chk("cl_rvalid", {31'b0, rvalid}, 32'h1);
    chk("cl_rdata", rdata, PAT);
    chk("cl_cnt", {28'b0, cnt}, 32'h0);
    chk("cl_empty", {31'b0, log_empty}, 32'h1);

    // Empty log, push and pop together.
    step(1, 1, 32'h9000_0000, 32'hDEADBEEF, 1, 0);
    #3;
    chk("ep_head", log_addr, 32'h9000_0000);
    chk("ep_we", {31'b0, log_we}, 32'h1);
`ifdef ERR_RESP_WDATA_LOG_EN
    chk("ep_wdata", log_wdata, 32'hDEADBEEF);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), $urandom_range(0, 1), $urandom, $urandom,
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 3));
    end

    // Asynchronous reset right after a handshake.
    step(1, 0, 32'hA000_0000, 32'h0, 0, 0);
    #3;
    chk("ar_pre_rvalid", {31'b0, rvalid}, 32'h1);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("ar_rvalid", {31'b0, rvalid}, 32'h0);
    chk("ar_rdata", rdata, 32'h0);
    chk("ar_empty", {31'b0, log_empty}, 32'h1);
    chk("ar_cnt", {28'b0, cnt}, 32'h0);
    chk("ar_irq", {31'b0, irq}, 32'h0);
    chk("ar_log_addr", log_addr, 32'h0);
    do_reset();
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
